sm3_rslt_otpt_srlz: RTL and testbench

- Output-side serializer for the SM3 core. It accepts the 256-bit digest from the compress stage as a single-cycle pulse.
- It streams the digest out as words on a bus with the same shape as the message input bus: data, valid, last and valid-byte, plus a ready backpressure signal.
- Sits between sm3_cmprss_core and the system result consumer. It is the transmit-side mirror of the message input interface.

---
 rtl/sm3_rslt_otpt_srlz_if.sv | 27 ++
 rtl/sm3_rslt_otpt_srlz.sv | 128 ++++++++++++
 tb/tb_sm3_rslt_otpt_srlz.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm3_rslt_otpt_srlz_if.sv
// Result output bus of the SM3 digest serializer: word data, byte enables,
// valid/last qualifiers and the downstream ready backpressure.
interface sm3_rslt_otpt_srlz_if #(
  parameter int OTPT_DW = 32
);
  logic [OTPT_DW-1:0]   rslt_otpt_d;
  logic [OTPT_DW/8-1:0] rslt_otpt_vld_byte;
  logic                 rslt_otpt_vld;
  logic                 rslt_otpt_lst;
  logic                 rslt_otpt_rdy;

  modport master (
    output rslt_otpt_d,
    output rslt_otpt_vld_byte,
    output rslt_otpt_vld,
    output rslt_otpt_lst,
    input  rslt_otpt_rdy
  );

  modport slave (
    input  rslt_otpt_d,
    input  rslt_otpt_vld_byte,
    input  rslt_otpt_vld,
    input  rslt_otpt_lst,
    output rslt_otpt_rdy
  );
endinterface

// File: rtl/sm3_rslt_otpt_srlz.sv
// Serializes a 256-bit SM3 digest into OTPT_DW-wide big-endian beats with valid/ready.
// Define SM3_RSLT_DBL_BUF_EN to add a pending buffer that absorbs a digest arriving mid-stream.
module sm3_rslt_otpt_srlz #(
  parameter int OTPT_DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [255:0]          cmprss_otpt_res,
  input  logic                  cmprss_otpt_vld,
  output logic                  cmprss_otpt_rdy,
  sm3_rslt_otpt_srlz_if.master  rslt,
  output logic                  rslt_ovfl_err
);
  localparam int BEAT_NUM = 256 / OTPT_DW;
  localparam int CNT_W    = $clog2(BEAT_NUM);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(BEAT_NUM - 2);

  generate
    if (OTPT_DW != 32 && OTPT_DW != 64) begin : g_bad_dw
      $error("sm3_rslt_otpt_srlz: OTPT_DW must be 32 or 64");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [255:0]     holding;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             last_xfer;
  logic             load;
  logic [255:0]     load_val;

  assign xfer      = rslt.rslt_otpt_vld & rslt.rslt_otpt_rdy;
  assign last_xfer = xfer & rslt.rslt_otpt_lst;

`ifdef SM3_RSLT_DBL_BUF_EN
  logic [255:0] pending;
  logic         pending_full;
  logic         pend_wr;

  assign cmprss_otpt_rdy = ~pending_full;

  // A buffered digest takes priority at the end of a stream; a fresh one is
  // loaded directly only when nothing is waiting.
  always_comb begin
    load     = 1'b0;
    load_val = cmprss_otpt_res;
    pend_wr  = 1'b0;
    if (last_xfer && pending_full) begin
      load     = 1'b1;
      load_val = pending;
    end else if (cmprss_otpt_vld && cmprss_otpt_rdy) begin
      if (state == IDLE || last_xfer) begin
        load = 1'b1;
      end else begin
        pend_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (pend_wr) begin
      pending      <= cmprss_otpt_res;
      pending_full <= 1'b1;
    end else if (last_xfer) begin
      pending_full <= 1'b0;
    end
  end
`else
  // Ready during the last accepted beat allows back-to-back digests with no bubble.
  assign cmprss_otpt_rdy = (state == IDLE) | (rslt.rslt_otpt_lst & rslt.rslt_otpt_rdy);
  assign load            = cmprss_otpt_vld & cmprss_otpt_rdy;
  assign load_val        = cmprss_otpt_res;
`endif

  // The data register holds the beat on the bus; holding keeps the remaining
  // words left-aligned so the next beat is always its top word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                   <= IDLE;
      holding                 <= '0;
      cnt                     <= '0;
      rslt.rslt_otpt_d        <= '0;
      rslt.rslt_otpt_vld_byte <= '0;
      rslt.rslt_otpt_vld      <= 1'b0;
      rslt.rslt_otpt_lst      <= 1'b0;
      rslt_ovfl_err           <= 1'b0;
    end else begin
      rslt_ovfl_err <= cmprss_otpt_vld & ~cmprss_otpt_rdy;
      if (load) begin
        state                   <= SEND;
        holding                 <= {load_val[255-OTPT_DW:0], {OTPT_DW{1'b0}}};
        cnt                     <= '0;
        rslt.rslt_otpt_d        <= load_val[255 -: OTPT_DW];
        rslt.rslt_otpt_vld_byte <= '1;
        rslt.rslt_otpt_vld      <= 1'b1;
        rslt.rslt_otpt_lst      <= 1'b0;
      end else if (last_xfer) begin
        state                   <= IDLE;
        holding                 <= '0;
        cnt                     <= '0;
        rslt.rslt_otpt_d        <= '0;
        rslt.rslt_otpt_vld_byte <= '0;
        rslt.rslt_otpt_vld      <= 1'b0;
        rslt.rslt_otpt_lst      <= 1'b0;
      end else if (xfer) begin
        holding            <= holding << OTPT_DW;
        cnt                <= cnt + 1'b1;
        rslt.rslt_otpt_d   <= holding[255 -: OTPT_DW];
        rslt.rslt_otpt_lst <= (cnt == CNT_PRE_LAST);
      end
    end
  end

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    rslt.rslt_otpt_vld && !rslt.rslt_otpt_rdy |=>
      rslt.rslt_otpt_vld && $stable(rslt.rslt_otpt_d) && $stable(rslt.rslt_otpt_lst));

  a_lst_vld: assert property (@(posedge clk) disable iff (!rst_n)
    rslt.rslt_otpt_lst |-> rslt.rslt_otpt_vld);

  a_byte_en: assert property (@(posedge clk) disable iff (!rst_n)
    rslt.rslt_otpt_vld |-> (rslt.rslt_otpt_vld_byte == '1));
endmodule

// File: tb/tb_sm3_rslt_otpt_srlz.sv
// Bench for sm3_rslt_otpt_srlz: vector table on 32/64-bit instances, directed
// corner sequences, and random traffic against a queue-based beat model.
module tb_sm3_rslt_otpt_srlz;
  localparam int BN = 8;
  localparam logic [255:0] ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [255:0] PAT  = 256'h01234567_89abcdef_fedcba98_76543210_00000000_ffffffff_a5a5a5a5_5a5a5a5a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] res32, res64;
  logic         cvld32, cvld64, crdy32, crdy64, err32, err64;

  always #5 clk = ~clk;

  sm3_rslt_otpt_srlz_if #(.OTPT_DW(32)) bus32 ();
  sm3_rslt_otpt_srlz_if #(.OTPT_DW(64)) bus64 ();

  sm3_rslt_otpt_srlz #(.OTPT_DW(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .cmprss_otpt_res(res32), .cmprss_otpt_vld(cvld32),
    .cmprss_otpt_rdy(crdy32), .rslt(bus32.master), .rslt_ovfl_err(err32)
  );

  sm3_rslt_otpt_srlz #(.OTPT_DW(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .cmprss_otpt_res(res64), .cmprss_otpt_vld(cvld64),
    .cmprss_otpt_rdy(crdy64), .rslt(bus64.master), .rslt_ovfl_err(err64)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0]      dw;
    logic [255:0]     res;
    logic [7:0][63:0] beats;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] dw, input logic [255:0] res,
                              input logic [63:0] b0, b1, b2, b3, b4, b5, b6, b7);
    vec_t v;
    v.dw = dw;
    v.res = res;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.beats[4] = b4; v.beats[5] = b5; v.beats[6] = b6; v.beats[7] = b7;
    return v;
  endfunction

  vec_t tbl [4];
  vec_t v;
  logic        p_vld, p_lst, p_rdy, p_err;
  logic [63:0] p_d;
  logic [7:0]  p_vb;

  task automatic peek(input logic [31:0] dw);
    if (dw == 32) begin
      p_vld = bus32.rslt_otpt_vld; p_lst = bus32.rslt_otpt_lst; p_d = 64'(bus32.rslt_otpt_d);
      p_vb = 8'(bus32.rslt_otpt_vld_byte); p_rdy = crdy32; p_err = err32;
    end else begin
      p_vld = bus64.rslt_otpt_vld; p_lst = bus64.rslt_otpt_lst; p_d = bus64.rslt_otpt_d;
      p_vb = bus64.rslt_otpt_vld_byte; p_rdy = crdy64; p_err = err64;
    end
  endtask

  // Reference model for the 32-bit instance: a queue of beats still owed downstream.
  typedef struct packed {
    logic [31:0] d;
    logic        lst;
  } beat_t;

  beat_t        mq[$];
  beat_t        mb;
  bit           mon_en = 1'b0;
  logic         m_err = 1'b0;
  logic         m_rdy;
  logic [255:0] m_t;

  always @(negedge clk) begin
    if (mon_en) begin
`ifdef SM3_RSLT_DBL_BUF_EN
      m_rdy = (mq.size() <= BN);
`else
      m_rdy = (mq.size() == 0) || (mq.size() == 1 && bus32.rslt_otpt_rdy);
`endif
      chk("m_vld", 64'(bus32.rslt_otpt_vld), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("m_d", 64'(bus32.rslt_otpt_d), 64'(mq[0].d));
        chk("m_lst", 64'(bus32.rslt_otpt_lst), 64'(mq[0].lst));
        chk("m_vb", 64'(bus32.rslt_otpt_vld_byte), 64'h0f);
      end else begin
        chk("m_lst_idle", 64'(bus32.rslt_otpt_lst), 64'd0);
      end
      chk("m_err", 64'(err32), 64'(m_err));
      chk("m_rdy", 64'(crdy32), 64'(m_rdy));
      if (mq.size() > 0 && bus32.rslt_otpt_rdy) void'(mq.pop_front());
      if (cvld32 && m_rdy) begin
        for (int k = 0; k < BN; k++) begin
          m_t = res32 >> (32 * (BN - 1 - k));
          mb.d = m_t[31:0];
          mb.lst = (k == BN - 1);
          mq.push_back(mb);
        end
      end
      m_err = cvld32 && !m_rdy;
      if (!rst_n) begin
        mq.delete();
        m_err = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    res32 = '0; cvld32 = 1'b0; res64 = '0; cvld64 = 1'b0;
    bus32.rslt_otpt_rdy = 1'b1;
    bus64.rslt_otpt_rdy = 1'b1;

    tbl[0] = mk(32, ABC, 64'h66c7f0f4, 64'h62eeedd9, 64'hd1f2d46b, 64'hdc10e4e2,
                64'h4167c487, 64'h5cf2f7a2, 64'h297da02b, 64'h8f4ba8e0);
    tbl[1] = mk(64, ABCD, 64'hdebe9ff92275b8a1, 64'h38604889c18e5a4d, 64'h6fdb70e5387e5765,
                64'h293dcba39c0c5732, 64'h0, 64'h0, 64'h0, 64'h0);
    tbl[2] = mk(32, PAT, 64'h01234567, 64'h89abcdef, 64'hfedcba98, 64'h76543210,
                64'h00000000, 64'hffffffff, 64'ha5a5a5a5, 64'h5a5a5a5a);
    tbl[3] = mk(64, ABC, 64'h66c7f0f462eeedd9, 64'hd1f2d46bdc10e4e2, 64'h4167c4875cf2f7a2,
                64'h297da02b8f4ba8e0, 64'h0, 64'h0, 64'h0, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(bus32.rslt_otpt_vld), 64'd0);
    chk("rst_lst", 64'(bus32.rslt_otpt_lst), 64'd0);
    chk("rst_d", 64'(bus32.rslt_otpt_d), 64'd0);
    chk("rst_vb", 64'(bus32.rslt_otpt_vld_byte), 64'd0);
    chk("rst_err", 64'(err32), 64'd0);
    chk("rst_vld64", 64'(bus64.rslt_otpt_vld), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step;
    chk("rel_rdy", 64'(crdy32), 64'd1);

    for (int i = 0; i < 4; i++) begin
      v = tbl[i];
      if (v.dw == 32) begin res32 = v.res; cvld32 = 1'b1; end
      else begin res64 = v.res; cvld64 = 1'b1; end
      peek(v.dw);
      chk("t_cap_rdy", 64'(p_rdy), 64'd1);
      step;
      cvld32 = 1'b0; cvld64 = 1'b0;
      for (int k = 0; k < int'(256 / v.dw); k++) begin
        peek(v.dw);
        chk("t_vld", 64'(p_vld), 64'd1);
        chk("t_d", p_d, v.beats[k]);
        chk("t_lst", 64'(p_lst), 64'(k == int'(256 / v.dw) - 1));
        chk("t_vb", 64'(p_vb), (v.dw == 32) ? 64'h0f : 64'hff);
        chk("t_err", 64'(p_err), 64'd0);
        step;
      end
      peek(v.dw);
      chk("t_done", 64'(p_vld), 64'd0);
      step;
    end

    // Backpressure: beat 2 stalled for three edges.
    res32 = ABC; cvld32 = 1'b1;
    step;
    cvld32 = 1'b0;
    for (int k = 0; k < BN; k++) begin
      chk("bp_d", 64'(bus32.rslt_otpt_d), tbl[0].beats[k]);
      chk("bp_vld", 64'(bus32.rslt_otpt_vld), 64'd1);
      if (k == 2) begin
        bus32.rslt_otpt_rdy = 1'b0;
        repeat (3) begin
          step;
          chk("bp_hold_d", 64'(bus32.rslt_otpt_d), 64'hd1f2d46b);
          chk("bp_hold_vld", 64'(bus32.rslt_otpt_vld), 64'd1);
          chk("bp_hold_lst", 64'(bus32.rslt_otpt_lst), 64'd0);
        end
        bus32.rslt_otpt_rdy = 1'b1;
      end
      step;
    end
    chk("bp_done", 64'(bus32.rslt_otpt_vld), 64'd0);
    step;

    // Back-to-back: second digest offered as the last beat transfers.
    res32 = ABC; cvld32 = 1'b1;
    step;
    cvld32 = 1'b0;
    for (int k = 0; k < 2 * BN; k++) begin
      chk("b2b_vld", 64'(bus32.rslt_otpt_vld), 64'd1);
      chk("b2b_d", 64'(bus32.rslt_otpt_d), (k < BN) ? tbl[0].beats[k] : tbl[2].beats[k - BN]);
      chk("b2b_lst", 64'(bus32.rslt_otpt_lst), 64'(k == BN - 1 || k == 2 * BN - 1));
      if (k == BN - 1) begin
        res32 = PAT; cvld32 = 1'b1;
        #1;
        chk("b2b_rdy", 64'(crdy32), 64'd1);
      end
      step;
      cvld32 = 1'b0;
    end
    chk("b2b_done", 64'(bus32.rslt_otpt_vld), 64'd0);
    step;

    // Overflow while a stream is in flight.
    res32 = ABC; cvld32 = 1'b1;
    step;
    cvld32 = 1'b0;
`ifdef SM3_RSLT_DBL_BUF_EN
    for (int k = 0; k < 2 * BN; k++) begin
      chk("ov_d", 64'(bus32.rslt_otpt_d), (k < BN) ? tbl[0].beats[k] : tbl[2].beats[k - BN]);
      chk("ov_err", 64'(err32), 64'(k == 4));
      if (k == 1 || k == 3) begin
        res32 = (k == 1) ? PAT : ABCD; cvld32 = 1'b1;
        #1;
        chk("ov_rdy", 64'(crdy32), 64'(k == 1));
      end
      step;
      cvld32 = 1'b0;
    end
`else
    for (int k = 0; k < BN; k++) begin
      chk("ov_d", 64'(bus32.rslt_otpt_d), tbl[0].beats[k]);
      chk("ov_err", 64'(err32), 64'(k == 4));
      if (k == 3) begin
        res32 = PAT; cvld32 = 1'b1;
        #1;
        chk("ov_rdy", 64'(crdy32), 64'd0);
      end
      step;
      cvld32 = 1'b0;
    end
`endif
    repeat (4) begin
      chk("ov_idle_vld", 64'(bus32.rslt_otpt_vld), 64'd0);
      chk("ov_idle_err", 64'(err32), 64'd0);
      step;
    end

    // Reset in the middle of a stream.
    res32 = ABC; cvld32 = 1'b1;
    step;
    cvld32 = 1'b0;
    repeat (4) step;
    chk("rs_beat4", 64'(bus32.rslt_otpt_d), 64'h4167c487);
    rst_n = 1'b0;
    step;
    chk("rs_vld", 64'(bus32.rslt_otpt_vld), 64'd0);
    chk("rs_lst", 64'(bus32.rslt_otpt_lst), 64'd0);
    chk("rs_err", 64'(err32), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rs_rdy", 64'(crdy32), 64'd1);
    step;
    chk("rs_quiet", 64'(bus32.rslt_otpt_vld), 64'd0);
    res32 = ABC; cvld32 = 1'b1;
    step;
    cvld32 = 1'b0;
    chk("rs_new_d", 64'(bus32.rslt_otpt_d), 64'h66c7f0f4);
    chk("rs_new_vld", 64'(bus32.rslt_otpt_vld), 64'd1);
    repeat (BN + 2) step;

    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 8; w++) res32[w*32 +: 32] = $urandom();
      cvld32 = ($urandom_range(0, 4) == 0);
      bus32.rslt_otpt_rdy = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 399) != 0);
      step;
    end
    rst_n = 1'b1;
    cvld32 = 1'b0;
    bus32.rslt_otpt_rdy = 1'b1;
    repeat (2 * BN + 4) step;
    chk("drain_vld", 64'(bus32.rslt_otpt_vld), 64'd0);
    chk("dw64_idle", 64'(bus64.rslt_otpt_vld), 64'd0);
    chk("dw64_err", 64'(err64), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
